// File: rtl/score_pkg.sv
// Shared types and default sizing for the score/timer decimal display path.
// The HUD and renderer placement logic use the same defaults.
package score_pkg;

    localparam int DEFAULT_BIN_WIDTH = 20;
    localparam int DEFAULT_DIGITS    = 6;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_adjust.sv
// Per-nibble add-3 correction that is applied before each double-dabble shift.
module bcd_adjust
    import score_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic [DIGITS*4-1:0] bcd_in,
    output logic [DIGITS*4-1:0] bcd_out
);

    digit_t nib;

    always_comb begin
        bcd_out = '0;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_in[i*4 +: 4];
            bcd_out[i*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// Iterative binary-to-BCD converter. Decimal digits for the renderer are committed
// in a single cycle, so a displayed frame never shows a partly converted value.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int BIN_WIDTH = DEFAULT_BIN_WIDTH,
    parameter int DIGITS    = DEFAULT_DIGITS,
    localparam int IDX_W    = $clog2(DIGITS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [BIN_WIDTH-1:0] value,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    input  logic [IDX_W-1:0]     digit_index,
    output digit_t               digit,
    output logic                 digit_blank
);

    localparam int          BCD_W   = DIGITS * 4;
    localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    conv_state_t            state, state_next;
    logic [BIN_WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_pending_q;
    logic                   done_q;
    logic                   overflow_q;
    digit_t                 committed_q [DIGITS];

    // An out-of-range value is shown as all nines rather than wrapped digits.
    function automatic digit_t sat_digit(input digit_t d, input logic sat);
        return sat ? 4'd9 : d;
    endfunction

    bcd_adjust #(.DIGITS(DIGITS)) u_bcd_adjust (
        .bcd_in  (bcd_q),
        .bcd_out (bcd_adj)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q       <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < DIGITS; i++) committed_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_q       <= value;
                        bcd_q         <= '0;
                        cnt_q         <= CNT_W'(BIN_WIDTH);
                        ovf_pending_q <= (64'(value) > MAX_VAL);
                    end
                end
                SHIFT: begin
                    // Bits leaving the top of the BCD register are dropped on purpose.
                    bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
                    shift_q <= {shift_q[BIN_WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        committed_q[i] <= sat_digit(bcd_q[i*4 +: 4], ovf_pending_q);
                    end
                    overflow_q <= ovf_pending_q;
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign overflow = overflow_q;

    // Read port: combinational from committed digits only.
    always_comb begin
        digit       = '0;
        digit_blank = 1'b1;
        if (int'(digit_index) < DIGITS) begin
            digit_blank = (digit_index != '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (i == int'(digit_index)) digit = committed_q[i];
                if (i >= int'(digit_index) && committed_q[i] != '0) digit_blank = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized and directed bench for score_bcd_converter against a decimal-arithmetic model.
module tb_score_bcd_converter;

    localparam int BW     = 20;
    localparam int DIGITS = 6;
    localparam int IDX_W  = 3;
    localparam int LAT    = BW + 1;
    localparam longint MAXV = 999999;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [BW-1:0]    value;
    logic             start;
    logic             busy, done, overflow;
    logic [IDX_W-1:0] digit_index;
    logic [3:0]       digit;
    logic             digit_blank;

    int n_checks = 0;
    int n_fail   = 0;

    score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .value       (value),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .digit_index (digit_index),
        .digit       (digit),
        .digit_blank (digit_blank)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: what the display should show for value v at position i.
    function automatic longint shown_value(input longint v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic longint exp_digit(input longint v, input int i);
        longint p = 1;
        if (i >= DIGITS) return 0;
        for (int k = 0; k < i; k++) p = p * 10;
        return (shown_value(v) / p) % 10;
    endfunction

    function automatic longint exp_blank(input longint v, input int i);
        longint p = 1;
        if (i == 0) return 0;
        if (i >= DIGITS) return 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (shown_value(v) / p == 0) ? 1 : 0;
    endfunction

    task automatic check_digits(input longint v, input string tag);
        check($sformatf("%s_ovf", tag), longint'(overflow), (v > MAXV) ? 1 : 0);
        for (int i = 0; i < 8; i++) begin
            digit_index = IDX_W'(i);
            #1;
            check($sformatf("%s_digit%0d", tag, i), longint'(digit), exp_digit(v, i));
            check($sformatf("%s_blank%0d", tag, i), longint'(digit_blank), exp_blank(v, i));
        end
    endtask

    // One conversion; optional stray start with another value part-way through.
    task automatic run_conv(input longint v, input string tag, input int stray_at, input longint stray_v);
        int  n  = 0;
        int  bc = 0;
        bit  seen = 0;
        @(negedge clock);
        value = BW'(v);
        start = 1'b1;
        while (!seen && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            start = 1'b0;
            if (n == stray_at) begin
                value = BW'(stray_v);
                start = 1'b1;
            end
            if (busy) bc++;
            if (done) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_latency"}, n - 1, LAT);
        check({tag, "_busy_cycles"}, bc, LAT);
        check_digits(v, tag);
        @(posedge clock);
        #1;
        check({tag, "_done_pulse"}, longint'(done), 0);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int     cnt;
        int     n;
        bit     seen;
        longint rv;

        reset_n     = 1'b0;
        start       = 1'b0;
        value       = '0;
        digit_index = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check_digits(0, "rst");
        @(negedge clock);
        reset_n = 1'b1;

        run_conv(0, "zero", -1, 0);
        run_conv(123456, "v123456", -1, 0);
        run_conv(999999, "v999999", -1, 0);
        run_conv(1000000, "v1000000", -1, 0);
        run_conv(1048575, "vmax", -1, 0);

        // Start with 7 arriving mid-conversion must be ignored and not queued.
        run_conv(42, "ignore", 5, 7);
        count_dones(30, cnt);
        check("ignore_no_queue", cnt, 0);

        for (int r = 0; r < 12; r++) begin
            rv = longint'($urandom_range(0, (1 << BW) - 1));
            run_conv(rv, $sformatf("rand%0d", r), -1, 0);
        end

        // Reset during a conversion aborts it.
        run_conv(555, "pre_abort", -1, 0);
        @(negedge clock);
        value = BW'(777);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check_digits(0, "abort");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        count_dones(40, cnt);
        check("abort_no_done", cnt, 0);
        run_conv(777, "post_abort", -1, 0);

        // Start held high: back-to-back conversions with one idle cycle between.
        @(negedge clock);
        value = BW'(10);
        start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (done) seen = 1;
        end
        check("b2b_first_latency", n - 1, LAT);
        check("b2b_busy_in_done", longint'(busy), 0);
        check_digits(10, "b2b10");
        value = BW'(11);
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check("b2b_period", n, LAT + 1);
        check_digits(11, "b2b11");
        count_dones(30, cnt);
        check("b2b_stop", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
